// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, round-stage FSM encoding, byte indexing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: STATE_W, state_e {IDLE, SUB, DONE}, byte_idx(r, c) = r + 4c.
package aes_pkg;

   localparam int STATE_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Byte number of (row r, column c) in the column-major AES state.
   function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
      return r + 4 * c;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational (shared by round stages).
// Latency: 0 cycles.
// Backpressure: none, no handshake.
// Ports: data_i (8) byte in, data_o (8) substituted byte out.
module aes_sbox (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   logic [7:0] sub;

   always_comb begin
      sub = 8'h00;
      case (data_i)
         8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
         8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
         8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
         8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
         8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
         8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
         8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
         8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
         8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
         8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
         8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
         8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
         8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
         8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
         8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
         8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
         8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
         8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
         8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
         8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
         8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
         8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
         8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
         8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
         8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
         8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
         8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
         8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
         8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
         8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
         8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
         8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
         default: sub = 8'h00;
      endcase
   end

   assign data_o = sub;

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes + ShiftRows: one column through four shared S-boxes per cycle.
// Latency: accept at edge T, out_valid after edge T+4; min period 6 cycles per block.
// Backpressure: in_ready only in IDLE; DONE holds out_valid/out_state until out_ready.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_state[127:0] from upstream;
//        out_valid/out_ready/out_state[127:0] to MixColumns; busy = SUB or DONE.
module aes_sub_shift
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               busy
);

   state_e             state_q;
   logic [1:0]         col_q;
   logic [STATE_W-1:0] buf_q;
   logic [STATE_W-1:0] buf_d;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [31:0]        col_word;
   logic [31:0]        sub_word;
   logic [STATE_W-1:0] shifted;

   // Column col_q of the working buffer feeds the shared S-boxes.
   always_comb begin
      col_word = '0;
      for (int c = 0; c < 4; c++) begin
         if (col_q == 2'(c)) col_word = buf_q[STATE_W-1-32*c -: 32];
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .data_i (col_word[31-8*i -: 8]),
         .data_o (sub_word[31-8*i -: 8])
      );
   end

   // Substituted column is written back in place; other columns untouched.
   always_comb begin
      buf_d = buf_q;
      for (int c = 0; c < 4; c++) begin
         if (col_q == 2'(c)) buf_d[STATE_W-1-32*c -: 32] = sub_word;
      end
   end

   // ShiftRows is pure wiring: row r rotates left by r columns.
   always_comb begin
      shifted = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            shifted[STATE_W-1-8*byte_idx(r, c) -: 8] =
               buf_q[STATE_W-1-8*byte_idx(r, (c + r) % 4) -: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= 2'd0;
         buf_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  buf_q      <= in_state;
                  col_q      <= 2'd0;
                  state_q    <= SUB;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            SUB: begin
               buf_q <= buf_d;
               // col wraps 3->0 here, so it is already cleared for the next block.
               col_q <= col_q + 2'd1;
               if (col_q == 2'd3) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = shifted;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift: vector table, backpressure, reset, streaming.
// Latency: n/a (testbench).
// Backpressure: exercised by holding out_ready low in DONE.
module tb_aes_sub_shift;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0]   sbox_t [256];
   logic [127:0] exp_q [$];

   typedef struct {
      logic [127:0] in;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [4];

   aes_sub_shift dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference S-box derived from GF(2^8) inverse + affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_ss(input logic [127:0] s);
      logic [7:0]   b [16];
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) b[k] = sbox_t[s[127-8*k -: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = b[r + 4*((c + r) % 4)];
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Scoreboard: push on accept, pop and compare on output transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(ref_ss(in_state));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_underflow: got output %h, expected no transfer", out_state);
            end else begin
               check("sb_out", out_state, exp_q.pop_front());
            end
         end
      end
   end

   // Offer st until accepted; returns whether the accept happened in budget.
   task automatic offer(input logic [127:0] st);
      bit acc;
      int n;
      in_state = st;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check("accept", 128'(acc), 128'd1);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input logic [127:0] st, input logic [127:0] exp, input bit chk_lat);
      int lat;
      offer(st);
      check("busy_sub", 128'(busy), 128'd1);
      wait_out(lat);
      if (chk_lat) check("latency", 128'(lat), 128'd5);
      check("out_valid", 128'(out_valid), 128'd1);
      check("vec_out", out_state, exp);
      @(posedge clk); #1;
      check("ov_drop", 128'(out_valid), 128'd0);
   endtask

   initial begin
      logic [127:0] exp_b;
      logic [127:0] s_arr [3];
      int           t [3];
      int           nx, idx, lat;
      bit           acc, xf;

      vecs[0].in = 128'h0;
      vecs[0].exp = 128'h63636363636363636363636363636363;
      vecs[1].in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      vecs[1].exp = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      vecs[2].in = 128'h00000000005300000000000000000000;
      vecs[2].exp = 128'h63ed6363636363636363636363636363;
      vecs[3].in = 128'hffffffffffffffffffffffffffffffff;
      vecs[3].exp = 128'h16161616161616161616161616161616;

      build_sbox();
      rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;

      repeat (3) @(posedge clk); #1;
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i].in, vecs[i].exp, i == 0);

      // Backpressure: stall 10 cycles in DONE, with ignored in_valid pulses.
      out_ready = 1'b0;
      offer(128'h00112233445566778899aabbccddeeff);
      exp_b = ref_ss(128'h00112233445566778899aabbccddeeff);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_state = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check("bp_valid", 128'(out_valid), 128'd1);
         check("bp_state", out_state, exp_b);
         check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ov", 128'(out_valid), 128'd0);
      check("bp_release_ir", 128'(in_ready), 128'd1);

      // Asynchronous reset during SUB discards the block.
      offer(128'hdeadbeef0123456789abcdeffedcba98);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(vecs[1].in, vecs[1].exp, 1'b1);

      // Streaming: three blocks, in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) s_arr[i] = {$urandom, $urandom, $urandom, $urandom};
      idx = 0; nx = 0;
      for (int i = 0; i < 3; i++) t[i] = 0;
      in_state = s_arr[0];
      in_valid = 1'b1;
      for (int cy = 0; cy < 60 && nx < 3; cy++) begin
         acc = in_valid && in_ready;
         xf  = out_valid && out_ready;
         @(posedge clk); #1;
         if (xf) begin t[nx] = cyc; nx++; end
         if (acc) begin
            idx++;
            if (idx < 3) in_state = s_arr[idx];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("stream_count", 128'(nx), 128'd3);
      check("stream_gap01", 128'(t[1] - t[0]), 128'd6);
      check("stream_gap12", 128'(t[2] - t[1]), 128'd6);

      @(negedge clk);
      check("sb_drain", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
